// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI slave receive path.
//   state_t        : receive FSM states (IDLE, RECV, FLUSH)
//   BYTE_BITS      : bits per shifted SPI byte
//   sample_on_rise : selects the SCLK edge on which MOSI is sampled
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int BYTE_BITS = 8;

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input int cpol, input int cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// Parameters:
//   DATA_W     : entry width ({tlast, tdata} = 9 bits by default)
//   FIFO_ABITS : log2 of the depth
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   wr_en/wr_data: push request; accepted when not full, or when full with
//                  a pop in the same cycle
//   rd_en        : pop the head entry (ignored when empty)
//   rd_data      : head entry, valid whenever empty is low
//   empty, full  : occupancy flags
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = BYTE_BITS + 1,
  parameter int FIFO_ABITS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int DEPTH = 2 ** FIFO_ABITS;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [FIFO_ABITS:0] wr_ptr;
  logic [FIFO_ABITS:0] rd_ptr;
  logic                do_wr;
  logic                do_rd;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_ABITS] != rd_ptr[FIFO_ABITS]) &&
                 (wr_ptr[FIFO_ABITS-1:0] == rd_ptr[FIFO_ABITS-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[FIFO_ABITS-1:0]];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr[FIFO_ABITS-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_rx_axis.sv
// SPI slave receive path: oversamples SCLK/CS/MOSI with the system clock and
// turns CS-delimited byte frames into an AXI4-Stream byte stream. The last
// byte of each frame carries tlast; it is only known once CS deasserts, so
// every byte waits in a holding register until the next byte or CS release.
// Optional build macro: SPI_RX_STATS_EN adds saturating frame/drop counters.
// Ports:
//   clock, reset      : system clock (>= 4x SCLK), synchronous active-high reset
//   spi_sclk_i        : SPI clock from the master (asynchronous)
//   spi_cs_ni         : chip select, active low (asynchronous)
//   spi_mosi_i        : master-out data (asynchronous)
//   m_axis_*          : AXI4-Stream byte output (tvalid/tready/tlast/tdata)
//   overflow_o        : sticky, a byte was dropped because the FIFO was full
//   frame_err_o       : one-cycle pulse, CS released with 1..7 stray bits
//   busy_o            : high while the FSM is not IDLE
//   frame_count_o     : (SPI_RX_STATS_EN) frames that delivered a final byte
//   drop_count_o      : (SPI_RX_STATS_EN) bytes dropped on a full FIFO
module spi_rx_axis
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_ABITS  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_sclk_i,
  input  logic                 spi_cs_ni,
  input  logic                 spi_mosi_i,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 m_axis_tlast_o,
  output logic [BYTE_BITS-1:0] m_axis_tdata_o,
  output logic                 overflow_o,
  output logic                 frame_err_o,
  output logic                 busy_o
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]          frame_count_o,
  output logic [15:0]          drop_count_o
`endif
);

  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam logic RISE_EDGE = sample_on_rise(CPOL, CPHA);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sample_edge;

  state_t                 state;
  logic [2:0]             bit_cnt;
  logic [BYTE_BITS-1:0]   shift_reg;
  logic [BYTE_BITS-1:0]   new_byte;
  logic [BYTE_BITS-1:0]   hold_data;
  logic                   hold_vld;

  logic                   cap_bit;
  logic                   byte_done;
  logic                   push_now;
  logic                   push_last;
  logic                   flush_byte;

  logic                   push_vld_p1;
  logic [BYTE_BITS:0]     push_dat_p1;

  logic [BYTE_BITS:0]     fifo_rd_data;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   pop;
  logic                   drop;

  // ---- stage p0: synchronisers and SCLK edge detect ----
  // Control syncs reset to idle levels so no false edge or CS is seen
  // right after reset release.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync   <= '1;
      sclk_d    <= SCLK_IDLE;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clock) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sample_edge = RISE_EDGE ? (sclk_s && !sclk_d) : (!sclk_s && sclk_d);

  // ---- stage p0 -> p1: receive FSM, shifter and holding register ----
  always_comb begin
    new_byte = (MSB_FIRST != 0) ? {shift_reg[BYTE_BITS-2:0], mosi_s}
                                : {mosi_s, shift_reg[BYTE_BITS-1:1]};
    // CS release wins over a coincident sample edge.
    cap_bit    = (state == RECV) && !cs_s && sample_edge;
    byte_done  = cap_bit && (bit_cnt == 3'd7);
    flush_byte = (state == FLUSH) && hold_vld;
    push_now   = (byte_done && hold_vld) || flush_byte;
    push_last  = (state == FLUSH);
  end

  always_ff @(posedge clock) begin
    if (cap_bit)   shift_reg   <= new_byte;
    if (byte_done) hold_data   <= new_byte;
    if (push_now)  push_dat_p1 <= {push_last, hold_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      hold_vld    <= 1'b0;
      push_vld_p1 <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      push_vld_p1 <= push_now;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state   <= RECV;
            bit_cnt <= '0;
            busy_o  <= 1'b1;
          end
        end
        RECV: begin
          if (cs_s) begin
            state   <= FLUSH;
            bit_cnt <= '0;
            if (bit_cnt != 3'd0) frame_err_o <= 1'b1;
          end else if (cap_bit) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) hold_vld <= 1'b1;
          end
        end
        FLUSH: begin
          hold_vld <= 1'b0;
          state    <= IDLE;
          busy_o   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1 -> FIFO: push, overflow detection ----
  assign pop  = m_axis_tvalid_o && m_axis_tready_i;
  assign drop = push_vld_p1 && fifo_full && !pop;

  spi_rx_fifo #(
    .DATA_W     (BYTE_BITS + 1),
    .FIFO_ABITS (FIFO_ABITS)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push_vld_p1),
    .wr_data (push_dat_p1),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end
  end

  // FIFO memory is not reset, so the head is masked while the FIFO is empty.
  assign m_axis_tvalid_o = !fifo_empty;
  assign m_axis_tlast_o  = m_axis_tvalid_o && fifo_rd_data[BYTE_BITS];
  assign m_axis_tdata_o  = m_axis_tvalid_o ? fifo_rd_data[BYTE_BITS-1:0] : '0;

`ifdef SPI_RX_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_o <= '0;
      drop_count_o  <= '0;
    end else begin
      if (flush_byte && (frame_count_o != 16'hFFFF)) frame_count_o <= frame_count_o + 16'd1;
      if (drop && (drop_count_o != 16'hFFFF))        drop_count_o  <= drop_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_rx_axis.sv
module tb_spi_rx_axis;

  localparam int HALF = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  // dut0: mode 0, MSB first
  logic       sclk0 = 1'b0;
  logic       cs0   = 1'b1;
  logic       mosi0 = 1'b0;
  logic       tready0 = 1'b1;
  logic       tvalid0, tlast0, ovf0, ferr0, busy0;
  logic [7:0] tdata0;

  // dut1: mode 3, LSB first
  logic       sclk1 = 1'b1;
  logic       cs1   = 1'b1;
  logic       mosi1 = 1'b0;
  logic       tready1 = 1'b1;
  logic       tvalid1, tlast1, ovf1, ferr1, busy1;
  logic [7:0] tdata1;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ferr_cnt0 = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  always #5 clock = ~clock;

  spi_rx_axis #(.SYNC_STAGES(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .FIFO_ABITS(2)) dut0 (
    .clock(clock), .reset(reset),
    .spi_sclk_i(sclk0), .spi_cs_ni(cs0), .spi_mosi_i(mosi0),
    .m_axis_tvalid_o(tvalid0), .m_axis_tready_i(tready0),
    .m_axis_tlast_o(tlast0), .m_axis_tdata_o(tdata0),
    .overflow_o(ovf0), .frame_err_o(ferr0), .busy_o(busy0)
  );

  spi_rx_axis #(.SYNC_STAGES(2), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .FIFO_ABITS(2)) dut1 (
    .clock(clock), .reset(reset),
    .spi_sclk_i(sclk1), .spi_cs_ni(cs1), .spi_mosi_i(mosi1),
    .m_axis_tvalid_o(tvalid1), .m_axis_tready_i(tready1),
    .m_axis_tlast_o(tlast1), .m_axis_tdata_o(tdata1),
    .overflow_o(ovf1), .frame_err_o(ferr1), .busy_o(busy1)
  );

  // Beat/pulse monitor on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (tvalid0 && tready0) q0.push_back({tlast0, tdata0});
    if (tvalid1 && tready1) q1.push_back({tlast1, tdata1});
    if (ferr0) ferr_cnt0++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Mode 0: MOSI set while SCLK low, sampled on the rising edge; MSB first.
  task automatic spi0_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi0 = v[i];
      wait_clk(HALF);
      sclk0 = 1'b1;
      wait_clk(HALF);
      sclk0 = 1'b0;
    end
  endtask

  task automatic cs0_low();
    cs0 = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs0_high(input int gap);
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(gap);
  endtask

  // Mode 3: MOSI changes on the falling (leading) edge, sampled on rising; LSB first.
  task automatic spi1_frame(input logic [7:0] v);
    cs1 = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 8; i++) begin
      sclk1 = 1'b0;
      mosi1 = v[i];
      wait_clk(HALF);
      sclk1 = 1'b1;
      wait_clk(HALF);
    end
    wait_clk(4);
    cs1 = 1'b1;
    wait_clk(8);
  endtask

  task automatic wait_beats0(input int n);
    int k;
    k = 0;
    while (q0.size() < n && k < 2000) begin
      wait_clk(1);
      k++;
    end
    wait_clk(20);
  endtask

  task automatic chk_beat0(input string tag, input int idx, input logic [8:0] exp);
    logic [31:0] got;
    got = (idx < q0.size()) ? {23'd0, q0[idx]} : 32'hDEAD;
    chk(tag, got, {23'd0, exp});
  endtask

  initial begin
    logic [31:0] got1;

    // ---- reset state ----
    wait_clk(5);
    chk("rst_tvalid", {31'd0, tvalid0}, 32'd0);
    chk("rst_tdata",  {24'd0, tdata0},  32'd0);
    reset = 1'b0;
    wait_clk(3);
    chk("idle_tvalid", {31'd0, tvalid0}, 32'd0);
    chk("idle_tlast",  {31'd0, tlast0},  32'd0);
    chk("idle_tdata",  {24'd0, tdata0},  32'd0);
    chk("idle_ovf",    {31'd0, ovf0},    32'd0);
    chk("idle_ferr",   {31'd0, ferr0},   32'd0);
    chk("idle_busy",   {31'd0, busy0},   32'd0);
    chk("idle_tvalid1",{31'd0, tvalid1}, 32'd0);

    // ---- mode 0 frame A5 3C 81 ----
    q0.delete(); ferr_cnt0 = 0;
    cs0_low();
    chk("busy_in_frame", {31'd0, busy0}, 32'd1);
    spi0_bits(32'hA5, 8);
    spi0_bits(32'h3C, 8);
    spi0_bits(32'h81, 8);
    cs0_high(8);
    wait_beats0(3);
    chk("f1_count", q0.size(), 32'd3);
    chk_beat0("f1_b0", 0, 9'h0A5);
    chk_beat0("f1_b1", 1, 9'h03C);
    chk_beat0("f1_b2", 2, 9'h181);
    chk("f1_ovf",  {31'd0, ovf0}, 32'd0);
    chk("f1_ferr", ferr_cnt0, 32'd0);
    chk("f1_busy", {31'd0, busy0}, 32'd0);

    // ---- 11-bit frame: F0 then 101 ----
    q0.delete(); ferr_cnt0 = 0;
    cs0_low();
    spi0_bits(32'h785, 11);
    cs0_high(8);
    wait_beats0(1);
    chk("f2_count", q0.size(), 32'd1);
    chk_beat0("f2_b0", 0, 9'h1F0);
    chk("f2_ferr", ferr_cnt0, 32'd1);

    // ---- overflow: tready low, 6-byte frame ----
    q0.delete(); ferr_cnt0 = 0;
    tready0 = 1'b0;
    cs0_low();
    spi0_bits(32'h10, 8);
    spi0_bits(32'h21, 8);
    spi0_bits(32'h32, 8);
    spi0_bits(32'h43, 8);
    spi0_bits(32'h54, 8);
    spi0_bits(32'h65, 8);
    cs0_high(20);
    chk("f3_ovf",    {31'd0, ovf0},   32'd1);
    chk("f3_tvalid", {31'd0, tvalid0}, 32'd1);
    chk("f3_head",   {23'd0, tlast0, tdata0}, 32'h010);
    chk("f3_nobeat", q0.size(), 32'd0);
    tready0 = 1'b1;
    wait_beats0(4);
    chk("f3_count", q0.size(), 32'd4);
    chk_beat0("f3_b0", 0, 9'h010);
    chk_beat0("f3_b1", 1, 9'h021);
    chk_beat0("f3_b2", 2, 9'h032);
    chk_beat0("f3_b3", 3, 9'h043);
    chk("f3_ovf_sticky", {31'd0, ovf0}, 32'd1);

    // ---- reset mid-frame ----
    cs0_low();
    spi0_bits(32'h99, 8);
    spi0_bits(32'hA, 4);
    reset = 1'b1;
    wait_clk(2);
    chk("mr_tvalid", {31'd0, tvalid0}, 32'd0);
    chk("mr_tlast",  {31'd0, tlast0},  32'd0);
    chk("mr_tdata",  {24'd0, tdata0},  32'd0);
    chk("mr_ovf",    {31'd0, ovf0},    32'd0);
    chk("mr_busy",   {31'd0, busy0},   32'd0);
    chk("mr_ferr",   {31'd0, ferr0},   32'd0);
    cs0 = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    q0.delete(); ferr_cnt0 = 0;
    cs0_low();
    spi0_bits(32'h55, 8);
    cs0_high(8);
    wait_beats0(1);
    chk("mr_count", q0.size(), 32'd1);
    chk_beat0("mr_b0", 0, 9'h155);
    chk("mr_ovf_after", {31'd0, ovf0}, 32'd0);

    // ---- back-to-back frames, CS high for 3 cycles ----
    q0.delete(); ferr_cnt0 = 0;
    cs0_low();
    spi0_bits(32'h11, 8);
    wait_clk(4);
    cs0 = 1'b1;
    wait_clk(3);
    cs0_low();
    spi0_bits(32'h22, 8);
    cs0_high(8);
    wait_beats0(2);
    chk("bb_count", q0.size(), 32'd2);
    chk_beat0("bb_b0", 0, 9'h111);
    chk_beat0("bb_b1", 1, 9'h122);
    chk("bb_ferr", ferr_cnt0, 32'd0);

    // ---- mode 3, LSB first, byte 0x01 ----
    q1.delete();
    spi1_frame(8'h01);
    wait_clk(20);
    chk("m3_count", q1.size(), 32'd1);
    got1 = (q1.size() > 0) ? {23'd0, q1[0]} : 32'hDEAD;
    chk("m3_b0", got1, 32'h101);
    chk("m3_ovf", {31'd0, ovf1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
